// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: FSM encoding and legal configuration ranges for the BRAM burst reader
package bram_rd_pkg;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;
   function automatic bit cfg_ok(int rd_lat, int fifo_d);
      return rd_lat >= RD_LAT_MIN && rd_lat <= RD_LAT_MAX && fifo_d >= rd_lat + 1 && (fifo_d & (fifo_d - 1)) == 0;
   endfunction
endpackage

// File: rtl/bram_burst_reader_fifo.sv
// rd_skid_fifo: small synchronous FIFO absorbing BRAM read data while the sink stalls
module rd_skid_fifo #(
   parameter int DATA_W = 16,
   parameter int FIFO_D = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DATA_W-1:0]            din,
   output logic [DATA_W-1:0]            dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(FIFO_D):0]      count
);
   localparam int AW = $clog2(FIFO_D);
   localparam int CW = AW + 1;
   logic [DATA_W-1:0] mem [FIFO_D];
   logic [AW-1:0]     wp, rp;
   logic              do_push, do_pop;
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign full    = count == CW'(FIFO_D);
   assign empty   = count == '0;
   assign dout    = mem[rp];
   // storage needs no reset: only words behind a valid count are ever read
   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
   // pointers and occupancy; power-of-2 depth lets pointers wrap naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/bram_burst_reader.sv
// bram_burst_reader: streams a BRAM burst onto a valid/ready stream behind a credit-limited skid FIFO
module bram_burst_reader
   import bram_rd_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1,
   parameter int FIFO_D = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready
);
   localparam int CW = $clog2(FIFO_D) + 1;
   localparam logic [CW-1:0] DEPTH = CW'(FIFO_D);
   if (!cfg_ok(RD_LAT, FIFO_D)) begin : g_bad_cfg
      $error("bram_burst_reader: RD_LAT must be 1..2 and FIFO_D a power of 2 >= RD_LAT+1");
   end
   rd_state_t         state, nxt;
   logic [ADDR_W:0]   issued, popped, burst_len, last_idx;
   logic [ADDR_W-1:0] addr;
   logic [RD_LAT-1:0] vld;
   logic [CW-1:0]     inflight, count;
   logic              push, pop, empty, full;
   assign push     = vld[RD_LAT-1];
   assign pop      = m_valid & m_ready;
   assign m_valid  = !empty;
   assign ram_addr = addr;
   assign last_idx = burst_len - (ADDR_W+1)'(1);
   assign m_last   = m_valid && popped == last_idx;
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= nxt;
   end
   // next state and control; a read issues only while a FIFO slot is guaranteed for its data
   always_comb begin
      nxt    = state;
      busy   = state == READ || state == DRAIN;
      done   = state == DONE;
      ram_en = state == READ && issued != burst_len && !full && (inflight + count) < DEPTH;
      case (state)
         IDLE:    nxt = start ? (len == '0 ? DONE : READ) : IDLE;
         READ:    nxt = issued == burst_len ? DRAIN : READ;
         DRAIN:   nxt = pop && m_last ? DONE : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   // burst bookkeeping: latch request in IDLE, then advance address/issue and pop counts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr      <= '0;
         burst_len <= '0;
         issued    <= '0;
         popped    <= '0;
      end else if (state == IDLE && start) begin
         addr      <= start_addr;
         burst_len <= len;
         issued    <= '0;
         popped    <= '0;
      end else begin
         if (ram_en) begin
            addr   <= addr + ADDR_W'(1);
            issued <= issued + (ADDR_W+1)'(1);
         end
         if (pop) popped <= popped + (ADDR_W+1)'(1);
      end
   end
   // read-latency tracker; its tail marks the cycle ram_dout carries requested data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld      <= '0;
         inflight <= '0;
      end else begin
         vld      <= (vld << 1) | RD_LAT'(ram_en);
         inflight <= inflight + CW'(ram_en) - CW'(push);
      end
   end
   rd_skid_fifo #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (ram_dout),
      .dout  (m_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );
endmodule

// File: tb/tb_bram_burst_reader.sv
// tb_bram_burst_reader: directed checks of the burst reader with RD_LAT=1 (lane 0) and RD_LAT=2 (lane 1)
module tb_bram_burst_reader;
   logic        clk = 0, rst = 0, start = 0, m_ready = 0, clr = 1;
   logic [3:0]  start_addr = 0;
   logic [4:0]  len = 0;
   logic        busy [2], done [2], ram_en [2], m_valid [2], m_last [2];
   logic [3:0]  ram_addr [2];
   logic [15:0] ram_dout [2], m_data [2], q1 [2], q2 [2], held [2];
   logic [15:0] mem [16];
   logic [15:0] rec_data [2][32];
   logic        rec_last [2][32];
   logic        stall [2];
   int cyc [2], n [2], en_n [2], vld_n [2], busy_n [2], done_n [2], done_cyc [2];
   int first_en [2], first_vld [2], last_hs [2], stab [2];
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_lane
      bram_burst_reader #(.ADDR_W(4), .DATA_W(16), .RD_LAT(g + 1), .FIFO_D(4)) dut (
         .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
         .busy(busy[g]), .done(done[g]), .ram_en(ram_en[g]), .ram_addr(ram_addr[g]),
         .ram_dout(ram_dout[g]), .m_valid(m_valid[g]), .m_data(m_data[g]),
         .m_last(m_last[g]), .m_ready(m_ready)
      );
      assign ram_dout[g] = g == 0 ? q1[g] : q2[g];
   end
   // BRAM model: registered read, plus an always-enabled output register for lane 1
   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (ram_en[l]) q1[l] <= mem[ram_addr[l]];
         q2[l] <= q1[l];
      end
   end
   // stream monitor: records handshakes, event counts and first/last cycles between edges
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (clr) begin
            cyc[l] <= 1; n[l] <= 0; en_n[l] <= 0; vld_n[l] <= 0; busy_n[l] <= 0; done_n[l] <= 0;
            done_cyc[l] <= 0; first_en[l] <= 0; first_vld[l] <= 0; last_hs[l] <= 0; stab[l] <= 0; stall[l] <= 0;
         end else begin
            cyc[l] <= cyc[l] + 1;
            if (ram_en[l]) en_n[l] <= en_n[l] + 1;
            if (ram_en[l] && first_en[l] == 0) first_en[l] <= cyc[l];
            if (m_valid[l]) vld_n[l] <= vld_n[l] + 1;
            if (m_valid[l] && first_vld[l] == 0) first_vld[l] <= cyc[l];
            if (busy[l]) busy_n[l] <= busy_n[l] + 1;
            if (done[l]) done_n[l] <= done_n[l] + 1;
            if (done[l]) done_cyc[l] <= cyc[l];
            if (stall[l] && (!m_valid[l] || m_data[l] !== held[l])) stab[l] <= stab[l] + 1;
            stall[l] <= m_valid[l] && !m_ready;
            held[l] <= m_data[l];
            if (m_valid[l] && m_ready) begin
               if (n[l] < 32) rec_data[l][n[l]] <= m_data[l];
               if (n[l] < 32) rec_last[l][n[l]] <= m_last[l];
               n[l] <= n[l] + 1;
               last_hs[l] <= cyc[l];
            end
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic start_burst(input logic [3:0] a, input logic [4:0] cnt, input bit clear);
      start = 1; start_addr = a; len = cnt; clr = clear;
      step();
      start = 0; clr = 0;
   endtask
   task automatic wait_done(input int budget, output bit ok);
      for (int i = 0; i < budget && !(done_n[0] > 0 && done_n[1] > 0); i++) step();
      ok = done_n[0] > 0 && done_n[1] > 0;
      repeat (3) step();
   endtask
   function automatic int seq_bad(int l, int a, int cnt);
      int b = 0;
      logic [15:0] e;
      for (int i = 0; i < cnt && i < 32; i++) begin
         e = 16'hA000 + 16'((a + i) % 16);
         if (rec_data[l][i] !== e || rec_last[l][i] !== (i == cnt - 1)) b++;
      end
      return b;
   endfunction
   task automatic test_reset();
      for (int l = 0; l < 2; l++) begin
         checks++;
         if ({busy[l], done[l], ram_en[l], m_valid[l], m_last[l], ram_addr[l]} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs lane%0d got %b want 0", l, {busy[l], done[l], ram_en[l], m_valid[l], m_last[l], ram_addr[l]});
         end
      end
   endtask
   task automatic test_stream(input string nm, input logic [3:0] a, input int cnt);
      bit ok;
      m_ready = 1;
      start_burst(a, 5'(cnt), 1);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout done seen lane0=%0d lane1=%0d want 1", nm, done_n[0], done_n[1]); end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (n[l] !== cnt) begin errors++; $display("FAIL %s_count lane%0d got %0d want %0d", nm, l, n[l], cnt); end
         checks++;
         if (seq_bad(l, a, cnt) !== 0) begin errors++; $display("FAIL %s_data lane%0d bad_words=%0d want 0", nm, l, seq_bad(l, a, cnt)); end
         checks++;
         if (first_en[l] !== 1) begin errors++; $display("FAIL %s_first_en lane%0d got cycle %0d want 1", nm, l, first_en[l]); end
         checks++;
         if (first_vld[l] !== 3 + l) begin errors++; $display("FAIL %s_first_valid lane%0d got cycle %0d want %0d", nm, l, first_vld[l], 3 + l); end
         checks++;
         if (last_hs[l] !== 3 + l + cnt - 1) begin errors++; $display("FAIL %s_throughput lane%0d last at %0d want %0d", nm, l, last_hs[l], 3 + l + cnt - 1); end
         checks++;
         if (done_n[l] !== 1 || done_cyc[l] !== last_hs[l] + 1) begin
            errors++; $display("FAIL %s_done lane%0d pulses=%0d at %0d want 1 at %0d", nm, l, done_n[l], done_cyc[l], last_hs[l] + 1);
         end
         checks++;
         if (busy_n[l] !== done_cyc[l] - 1) begin errors++; $display("FAIL %s_busy lane%0d cycles=%0d want %0d", nm, l, busy_n[l], done_cyc[l] - 1); end
         checks++;
         if (en_n[l] !== cnt) begin errors++; $display("FAIL %s_reads lane%0d got %0d want %0d", nm, l, en_n[l], cnt); end
      end
   endtask
   task automatic test_backpressure();
      bit ok;
      m_ready = 1;
      start_burst(4'd2, 5'd8, 1);
      for (int i = 0; i < 4; i++) begin m_ready = (i % 2 == 0); step(); end
      m_ready = 0;
      repeat (10) step();
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (ram_en[l] !== 1'b0 || en_n[l] - n[l] !== 4) begin
            errors++; $display("FAIL bp_credit lane%0d ram_en=%b outstanding=%0d want 0/4", l, ram_en[l], en_n[l] - n[l]);
         end
         checks++;
         if (m_valid[l] !== 1'b1) begin errors++; $display("FAIL bp_valid_held lane%0d got %b want 1", l, m_valid[l]); end
      end
      m_ready = 1;
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_timeout done seen lane0=%0d lane1=%0d want 1", done_n[0], done_n[1]); end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (n[l] !== 8) begin errors++; $display("FAIL bp_count lane%0d got %0d want 8", l, n[l]); end
         checks++;
         if (seq_bad(l, 2, 8) !== 0) begin errors++; $display("FAIL bp_data lane%0d bad_words=%0d want 0", l, seq_bad(l, 2, 8)); end
         checks++;
         if (stab[l] !== 0) begin errors++; $display("FAIL bp_stable lane%0d violations=%0d want 0", l, stab[l]); end
         checks++;
         if (en_n[l] !== 8) begin errors++; $display("FAIL bp_reads lane%0d got %0d want 8", l, en_n[l]); end
      end
   endtask
   task automatic test_zero_len();
      m_ready = 1;
      start_burst(4'd3, 5'd0, 1);
      repeat (6) step();
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (en_n[l] !== 0 || vld_n[l] !== 0) begin errors++; $display("FAIL zero_quiet lane%0d reads=%0d valids=%0d want 0/0", l, en_n[l], vld_n[l]); end
         checks++;
         if (done_n[l] !== 1 || done_cyc[l] !== 1) begin errors++; $display("FAIL zero_done lane%0d pulses=%0d at %0d want 1 at 1", l, done_n[l], done_cyc[l]); end
         checks++;
         if (busy_n[l] > 1) begin errors++; $display("FAIL zero_busy lane%0d cycles=%0d want <=1", l, busy_n[l]); end
      end
   endtask
   task automatic test_ignore_start();
      bit ok;
      m_ready = 1;
      start_burst(4'd0, 5'd6, 1);
      repeat (2) step();
      start_burst(4'd5, 5'd3, 0);
      wait_done(200, ok);
      repeat (5) step();
      checks++;
      if (!ok) begin errors++; $display("FAIL ign_timeout done seen lane0=%0d lane1=%0d want 1", done_n[0], done_n[1]); end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (n[l] !== 6 || seq_bad(l, 0, 6) !== 0) begin errors++; $display("FAIL ign_data lane%0d count=%0d bad=%0d want 6/0", l, n[l], seq_bad(l, 0, 6)); end
         checks++;
         if (en_n[l] !== 6 || done_n[l] !== 1 || busy[l] !== 1'b0) begin
            errors++; $display("FAIL ign_no_rerun lane%0d reads=%0d dones=%0d busy=%b want 6/1/0", l, en_n[l], done_n[l], busy[l]);
         end
      end
   endtask
   task automatic test_reset_mid();
      bit ok;
      m_ready = 1;
      start_burst(4'd0, 5'd16, 1);
      for (int i = 0; i < 30 && n[0] < 3; i++) step();
      checks++;
      if (n[0] < 3) begin errors++; $display("FAIL rstmid_progress lane0 words=%0d want 3", n[0]); end
      rst = 0;
      #1;
      test_reset();
      repeat (2) step();
      rst = 1;
      step();
      start_burst(4'd8, 5'd4, 1);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_timeout done seen lane0=%0d lane1=%0d want 1", done_n[0], done_n[1]); end
      for (int l = 0; l < 2; l++) begin
         checks++;
         if (n[l] !== 4 || seq_bad(l, 8, 4) !== 0) begin errors++; $display("FAIL rstmid_data lane%0d count=%0d bad=%0d want 4/0", l, n[l], seq_bad(l, 8, 4)); end
         checks++;
         if (first_vld[l] !== 3 + l || done_n[l] !== 1) begin
            errors++; $display("FAIL rstmid_clean lane%0d first_valid=%0d dones=%0d want %0d/1", l, first_vld[l], done_n[l], 3 + l);
         end
      end
   endtask
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
      repeat (2) step();
      test_reset();
      rst = 1;
      step();
      test_stream("full", 4'd0, 16);
      test_stream("wrap", 4'd14, 4);
      test_backpressure();
      test_zero_len();
      test_ignore_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
